// File: rtl/imu_frame_streamer.sv
// IMU frame streamer: assembles 10-byte big-endian sensor frames and presents them
// on an AXI4-Stream style output through a 2-entry frame FIFO.
module imu_frame_streamer #(
    parameter int unsigned OVR_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           BYTE_IN,
    input  logic                 BYTE_VALID,
    input  logic                 FRAME_START,
    output logic [15:0]          RAW_ACCL_X,
    output logic [15:0]          RAW_ACCL_Y,
    output logic [15:0]          RAW_ACCL_Z,
    output logic [15:0]          RAW_GYRO_X,
    output logic [15:0]          RAW_GYRO_Y,
    output logic                 TVALID,
    input  logic                 TREADY,
    output logic [OVR_WIDTH-1:0] OVERRUN_COUNT,
    output logic                 FRAMING_ERR
);

    typedef enum logic [0:0] {StIdle, StCollect} state_e;

    state_e               state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic [71:0]          asm_q, asm_d;
    logic                 ferr_q, ferr_d;
    logic [OVR_WIDTH-1:0] ovr_q, ovr_d;

    logic                 push;
    logic [79:0]          push_data;

    logic [79:0]          mem_q [2];
    logic                 rd_ptr_q, wr_ptr_q;
    logic [1:0]           count_q, count_d;
    logic                 pop, full, accept, drop;
    logic [79:0]          head;

    // Bytes shift in from the bottom, so byte 0 ends up in the top bits of the frame.
    assign push_data = {asm_q, BYTE_IN};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        ferr_d  = ferr_q;
        push    = 1'b0;
        if (BYTE_VALID) begin
            unique case (state_q)
                StIdle: begin
                    if (FRAME_START) begin
                        asm_d   = {64'd0, BYTE_IN};
                        idx_d   = 4'd1;
                        state_d = StCollect;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                StCollect: begin
                    if (FRAME_START) begin
                        // Resync: drop the partial frame and start over with this byte.
                        ferr_d = 1'b1;
                        asm_d  = {64'd0, BYTE_IN};
                        idx_d  = 4'd1;
                    end else if (idx_q == 4'd9) begin
                        push    = 1'b1;
                        idx_d   = 4'd0;
                        state_d = StIdle;
                    end else begin
                        asm_d = {asm_q[63:0], BYTE_IN};
                        idx_d = idx_q + 4'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign full   = (count_q == 2'd2);
    assign pop    = (count_q != 2'd0) && TREADY;
    // A simultaneous pop frees the slot, so a push to a full FIFO still lands.
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    always_comb begin
        count_d = count_q;
        ovr_d   = ovr_q;
        unique case ({accept, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (drop && (ovr_q != {OVR_WIDTH{1'b1}})) begin
            ovr_d = ovr_q + OVR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= 4'd0;
            asm_q    <= '0;
            ferr_q   <= 1'b0;
            ovr_q    <= '0;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            count_q <= count_d;
            if (accept) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign RAW_ACCL_X    = head[79:64];
    assign RAW_ACCL_Y    = head[63:48];
    assign RAW_ACCL_Z    = head[47:32];
    assign RAW_GYRO_X    = head[31:16];
    assign RAW_GYRO_Y    = head[15:0];
    assign TVALID        = (count_q != 2'd0);
    assign OVERRUN_COUNT = ovr_q;
    assign FRAMING_ERR   = ferr_q;

endmodule

// File: tb/tb_imu_frame_streamer.sv
// Scoreboard bench for imu_frame_streamer: stimulus pushes expected frames, a negedge
// monitor pops and compares on every TVALID/TREADY handshake.
module tb_imu_frame_streamer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  BYTE_IN;
    logic        BYTE_VALID;
    logic        FRAME_START;
    logic [15:0] RAW_ACCL_X, RAW_ACCL_Y, RAW_ACCL_Z, RAW_GYRO_X, RAW_GYRO_Y;
    logic        TVALID;
    logic        TREADY;
    logic [7:0]  OVERRUN_COUNT;
    logic        FRAMING_ERR;

    int tests = 0;
    int fails = 0;

    logic [79:0] exp_q [$];
    logic [79:0] head;
    logic [79:0] prev_head;
    logic        prev_stall = 1'b0;

    localparam logic [79:0] FrA = 80'h8000_7FFF_0001_FFFE_1234;
    localparam logic [79:0] FrB = 80'h0102_0304_0506_0708_090A;
    localparam logic [79:0] FrC = 80'hDEAD_BEEF_CAFE_F00D_5A5A;
    localparam logic [79:0] FrD = 80'h7FFF_8000_FFFF_0000_A55A;

    imu_frame_streamer #(.OVR_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .BYTE_IN       (BYTE_IN),
        .BYTE_VALID    (BYTE_VALID),
        .FRAME_START   (FRAME_START),
        .RAW_ACCL_X    (RAW_ACCL_X),
        .RAW_ACCL_Y    (RAW_ACCL_Y),
        .RAW_ACCL_Z    (RAW_ACCL_Z),
        .RAW_GYRO_X    (RAW_GYRO_X),
        .RAW_GYRO_Y    (RAW_GYRO_Y),
        .TVALID        (TVALID),
        .TREADY        (TREADY),
        .OVERRUN_COUNT (OVERRUN_COUNT),
        .FRAMING_ERR   (FRAMING_ERR)
    );

    always #5 clk = ~clk;

    assign head = {RAW_ACCL_X, RAW_ACCL_Y, RAW_ACCL_Z, RAW_GYRO_X, RAW_GYRO_Y};

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: handshakes pop the scoreboard; stalls must keep the head stable.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else if (TVALID && TREADY) begin
            prev_stall <= 1'b0;
            if (exp_q.size() == 0) begin
                check("unexpected_frame", head, 80'hx);
            end else begin
                check("frame_data", head, exp_q.pop_front());
            end
        end else if (TVALID && !TREADY) begin
            if (prev_stall) check("stall_stable", head, prev_head);
            prev_stall <= 1'b1;
            prev_head  <= head;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic s);
        BYTE_IN     = b;
        FRAME_START = s;
        BYTE_VALID  = 1'b1;
        @(posedge clk);
        #1;
        BYTE_VALID  = 1'b0;
        FRAME_START = 1'b0;
    endtask

    task automatic send_frame(input logic [79:0] f, input int nbytes);
        for (int i = 0; i < nbytes; i++) send_byte(f[79-8*i -: 8], i == 0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check({name, "_drained"}, 80'(exp_q.size()), 80'd0);
        check({name, "_tvalid_low"}, 80'(TVALID), 80'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        BYTE_IN = 8'h55;
        FRAME_START = 1'b0;
        BYTE_VALID = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        BYTE_VALID = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        BYTE_IN = 8'h00;
        BYTE_VALID = 1'b0;
        FRAME_START = 1'b0;
        TREADY = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_tvalid", 80'(TVALID), 80'd0);
        check("rst_raw", head, 80'd0);
        check("rst_ovr", 80'(OVERRUN_COUNT), 80'd0);
        check("rst_ferr", 80'(FRAMING_ERR), 80'd0);

        // Single frame, one-cycle pulse
        TREADY = 1'b1;
        exp_q.push_back(FrA);
        send_frame(FrA, 10);
        check("single_latency", 80'(TVALID), 80'd1);
        @(posedge clk);
        #1;
        check("single_pulse", 80'(TVALID), 80'd0);
        drain("single");

        // Backpressure: C dropped
        TREADY = 1'b0;
        exp_q.push_back(FrA);
        exp_q.push_back(FrB);
        send_frame(FrA, 10);
        send_frame(FrB, 10);
        send_frame(FrC, 10);
        check("bp_tvalid", 80'(TVALID), 80'd1);
        check("bp_head", head, FrA);
        check("bp_ovr", 80'(OVERRUN_COUNT), 80'd1);
        TREADY = 1'b1;
        drain("bp");

        // Full with simultaneous pop
        TREADY = 1'b0;
        exp_q.push_back(FrA);
        exp_q.push_back(FrB);
        exp_q.push_back(FrC);
        send_frame(FrA, 10);
        send_frame(FrB, 10);
        send_frame(FrC, 9);
        TREADY = 1'b1;
        send_byte(FrC[7:0], 1'b0);
        check("fullpop_ovr", 80'(OVERRUN_COUNT), 80'd1);
        drain("fullpop");
        check("no_ferr_yet", 80'(FRAMING_ERR), 80'd0);

        // Resync after 5 bytes
        exp_q.push_back(FrB);
        send_frame(FrA, 5);
        send_frame(FrB, 10);
        drain("resync");
        check("resync_ferr", 80'(FRAMING_ERR), 80'd1);

        // Reset mid-stream
        TREADY = 1'b0;
        send_frame(FrA, 10);
        send_frame(FrB, 4);
        pulse_reset();
        check("midrst_tvalid", 80'(TVALID), 80'd0);
        check("midrst_raw", head, 80'd0);
        check("midrst_ovr", 80'(OVERRUN_COUNT), 80'd0);
        check("midrst_ferr", 80'(FRAMING_ERR), 80'd0);
        TREADY = 1'b1;
        exp_q.push_back(FrD);
        send_frame(FrD, 10);
        drain("postrst");

        // Saturation: 2 buffered + 300 dropped
        TREADY = 1'b0;
        for (int n = 0; n < 302; n++) send_frame(FrD, 10);
        check("sat_ovr", 80'(OVERRUN_COUNT), 80'd255);
        check("sat_head", head, FrD);
        pulse_reset();
        check("sat_rst_ovr", 80'(OVERRUN_COUNT), 80'd0);

        // First byte after reset lacks FRAME_START
        TREADY = 1'b1;
        send_byte(8'h11, 1'b0);
        check("stray_ferr", 80'(FRAMING_ERR), 80'd1);
        check("stray_tvalid", 80'(TVALID), 80'd0);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imu_frame_streamer.md
IMU_FRAME_STREAMER -- requirements
Module: imu_frame_streamer

Interface
REQ-001 Parameter OVR_WIDTH, default 8, sets the width of the overrun counter.
REQ-002 clk  input  1  single clock; all logic is rising-edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 BYTE_IN  input  8  raw sensor byte from the bus reader.
REQ-005 BYTE_VALID  input  1  BYTE_IN is valid this cycle.
REQ-006 FRAME_START  input  1  qualified by BYTE_VALID; marks the first byte of a frame.
REQ-007 RAW_ACCL_X, RAW_ACCL_Y, RAW_ACCL_Z, RAW_GYRO_X, RAW_GYRO_Y  output  16 each  two's-complement sample words of the head frame.
REQ-008 TVALID  output  1  AXI4-Stream master valid.
REQ-009 TREADY  input  1  AXI4-Stream slave ready (from preprocessor).
REQ-010 OVERRUN_COUNT  output  OVR_WIDTH  count of frames dropped because the buffer was full; saturates.
REQ-011 FRAMING_ERR  output  1  sticky; a frame was aborted or a byte arrived outside a frame.

Function
REQ-012 A frame is 10 bytes, big-endian, in this order: ACCL_X, ACCL_Y, ACCL_Z, GYRO_X, GYRO_Y.
REQ-013 The assembler FSM has two states: IDLE and COLLECT; a 4-bit byte index runs 0..9.
REQ-014 In IDLE, BYTE_VALID with FRAME_START shall store the byte as index 0 and move to COLLECT with index 1.
REQ-015 In IDLE, BYTE_VALID without FRAME_START shall discard the byte and set FRAMING_ERR.
REQ-016 In COLLECT, BYTE_VALID without FRAME_START shall store the byte at the current index and increment the index.
REQ-017 In COLLECT, on the byte at index 9 the frame is complete: the FSM returns to IDLE and the frame is pushed to the buffer on the same clock edge.
REQ-018 In COLLECT, BYTE_VALID with FRAME_START shall discard the partial frame, set FRAMING_ERR, store the byte as index 0, and continue with index 1 (resync).
REQ-019 Cycles with BYTE_VALID low shall not advance the FSM; there is no timeout.
REQ-020 The output buffer is a 2-entry FIFO of 80-bit frames; RAW_* outputs are driven directly from the head entry.
REQ-021 TVALID shall be high whenever the FIFO is non-empty.
REQ-022 A pop occurs on any cycle where TVALID and TREADY are both high.
REQ-023 While TVALID is high and TREADY is low, RAW_* shall hold stable (AXI4-Stream rule).
REQ-024 Latency: a frame completed at edge N shall assert TVALID with its data after edge N when the FIFO was empty; there is no combinational path from BYTE_IN to the outputs.
REQ-025 Push and pop in the same cycle shall both take effect, including when the FIFO is full; a pop frees a slot in that cycle, so the push is accepted.
REQ-026 A push to a full FIFO with no simultaneous pop shall drop the new frame and increment OVERRUN_COUNT, which saturates at all-ones.
REQ-027 A pop from an empty FIFO is impossible because TVALID is low; TREADY is ignored while empty.
REQ-028 Frames shall leave the FIFO in arrival order, and a dropped frame shall never corrupt the stored entries.
REQ-029 FRAMING_ERR and OVERRUN_COUNT shall clear only on reset.

Reset
REQ-030 While reset is high at a clock edge: FSM to IDLE, byte index to 0, FIFO emptied, TVALID 0, RAW_* 0x0000, OVERRUN_COUNT 0, FRAMING_ERR 0.
REQ-031 Reset asserted mid-frame or with TVALID high shall discard all partial and buffered frames, and bytes presented during reset shall be ignored.
REQ-032 After reset deasserts, the first accepted byte shall be one with FRAME_START.

Verification
REQ-033 Single frame, TREADY=1: send bytes 80 00 7F FF 00 01 FF FE 12 34 with FRAME_START on the first byte -> one-cycle TVALID pulse with ACCL_X=0x8000, ACCL_Y=0x7FFF, ACCL_Z=0x0001, GYRO_X=0xFFFE, GYRO_Y=0x1234.
REQ-034 Backpressure: hold TREADY=0 and send 3 frames A, B, C -> TVALID high with A stable, OVERRUN_COUNT=1; then raise TREADY -> A then B delivered, C never appears.
REQ-035 Full with a simultaneous pop: FIFO holds A and B, TREADY=1 on the same edge C completes -> A popped, C accepted, OVERRUN_COUNT stays 0, output order A, B, C.
REQ-036 Resync: FRAME_START after byte 5 of frame A, then a full frame B -> only B output, FRAMING_ERR=1.
REQ-037 Reset mid-stream: assert reset with 1 frame buffered and 4 bytes collected -> next cycle TVALID=0, RAW_*=0, counters 0; a following full frame is delivered correctly.
REQ-038 Saturation: 300 dropped frames with OVR_WIDTH=8 -> OVERRUN_COUNT=255.
